// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding,
// parity-type constants and the parity helper.
package fifo_uart_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Even parity is the XOR-reduce of the payload; odd parity is its inverse.
  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    return data_xor ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/bit_tick_counter.sv
// Per-bit cycle counter: runs while enabled, wraps at Clks_per_bit-1 and
// flags the last cycle of each serial bit.
module bit_tick_counter #(
  parameter int Clks_per_bit = 4
) (
  input  logic Rclk,
  input  logic Rrst,
  input  logic En,
  output logic Tick
);

  localparam int CW = (Clks_per_bit > 1) ? $clog2(Clks_per_bit) : 1;
  localparam logic [CW-1:0] LAST = CW'(Clks_per_bit - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: advance while enabled, wrap at the last cycle of the bit.
  always_comb begin
    cnt_d = {CW{1'b0}};
    if (En) begin
      if (cnt_q == LAST) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // Counter register.
  always_ff @(posedge Rclk or posedge Rrst) begin
    if (Rrst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Tick = En && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Read-domain consumer of the async FIFO: pops one word per frame and
// serializes it as start, LSB-first data, optional parity and stop bits.
module fifo_uart_tx #(
  parameter int Data_width   = 8,
  parameter int Clks_per_bit = 4
) (
  input  logic                  Rclk,
  input  logic                  Rrst,
  input  logic                  Rempty,
  input  logic [Data_width-1:0] Rdata,
  input  logic                  Par_en,
  input  logic                  Par_typ,
  output logic                  Rinc,
  output logic                  Tx_out,
  output logic                  Busy
);
  import fifo_uart_tx_pkg::*;

  localparam int IW = (Data_width > 1) ? $clog2(Data_width) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(Data_width - 1);

  state_e                state_q, state_d;
  logic [Data_width-1:0] shift_q, shift_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  cnt_en_s;
  logic                  tick_s;

  assign cnt_en_s = (state_q != IDLE);

  bit_tick_counter #(
    .Clks_per_bit(Clks_per_bit)
  ) u_bit_tick (
    .Rclk (Rclk),
    .Rrst (Rrst),
    .En   (cnt_en_s),
    .Tick (tick_s)
  );

  // Gated by reset so no pop can escape while the block is held in reset.
  assign Rinc = (state_q == IDLE) && !Rempty && !Rrst;

  // Next-state, shift register and line value for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (Rinc) begin
          shift_d   = Rdata;
          par_en_d  = Par_en;
          par_bit_d = parity_bit(^Rdata, Par_typ);
          idx_d     = {IW{1'b0}};
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          tx_d    = shift_q[0];
          idx_d   = {IW{1'b0}};
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          if (idx_q == LAST_IDX) begin
            if (par_en_q) begin
              tx_d    = par_bit_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            idx_d   = idx_q + IW'(1);
            shift_d = {1'b0, shift_q[Data_width-1:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (tick_s) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (tick_s) begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers; reset drops any partially sent byte.
  always_ff @(posedge Rclk or posedge Rrst) begin
    if (Rrst) begin
      state_q   <= IDLE;
      shift_q   <= {Data_width{1'b0}};
      idx_q     <= {IW{1'b0}};
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign Tx_out = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a queue-based FWFT FIFO model feeds the
// DUT and a line monitor compares each frame against the expected waveform.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;

  typedef struct {
    logic [7:0] d;
    logic       pen;
    logic       ptyp;
  } item_t;

  logic          Rclk    = 1'b0;
  logic          Rrst    = 1'b1;
  logic          Rempty  = 1'b1;
  logic [DW-1:0] Rdata   = 8'h00;
  logic          Par_en  = 1'b0;
  logic          Par_typ = 1'b0;
  logic          Rinc;
  logic          Tx_out;
  logic          Busy;

  fifo_uart_tx #(.Data_width(DW), .Clks_per_bit(CPB)) dut (
    .Rclk    (Rclk),
    .Rrst    (Rrst),
    .Rempty  (Rempty),
    .Rdata   (Rdata),
    .Par_en  (Par_en),
    .Par_typ (Par_typ),
    .Rinc    (Rinc),
    .Tx_out  (Tx_out),
    .Busy    (Busy)
  );

  always #5 Rclk = ~Rclk;

  item_t fq[$];
  item_t exq[$];
  logic  rinc_samp = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic push_item(input logic [7:0] d, input logic pen, input logic ptyp);
    item_t it;
    it.d = d; it.pen = pen; it.ptyp = ptyp;
    fq.push_back(it);
    exq.push_back(it);
  endtask

  // FIFO model: pop on a sampled Rinc edge, present FWFT data, junk when empty.
  always @(posedge Rclk) rinc_samp <= Rinc;

  always @(posedge Rclk) begin
    item_t tmp;
    #1;
    if (rinc_samp) begin
      if (fq.size() == 0) begin
        check("pop_from_empty", 1, 0);
      end else begin
        tmp = fq.pop_front();
      end
    end
    if (fq.size() == 0) begin
      Rempty  = 1'b1;
      Rdata   = 8'($urandom);
      Par_en  = 1'($urandom);
      Par_typ = 1'($urandom);
    end else begin
      Rempty  = 1'b0;
      Rdata   = fq[0].d;
      Par_en  = fq[0].pen;
      Par_typ = fq[0].ptyp;
    end
  end

  // Line monitor and scoreboard.
  logic bits[$];
  logic last_bits[$];
  int   collecting = 0;
  int   gap = 0;
  bit   b2b = 1'b0;
  int   last_len = 0;
  int   rinc_cnt = 0;
  int   frames = 0;
  int   b2b_checks = 0;
  int   idle_low = 0;

  always @(negedge Rclk) begin
    item_t it;
    logic  e[$];
    int    ones;
    int    bad_idx;
    logic  p;
    if (Rinc) begin
      rinc_cnt++;
      check("rinc_legal", int'(Rempty || Busy), 0);
    end
    if (Rrst) begin
      if (collecting != 0 && exq.size() > 0) it = exq.pop_front();
      collecting = 0;
      bits.delete();
      gap = 0;
      b2b = 1'b0;
    end else if (Busy) begin
      if (collecting == 0) begin
        collecting = 1;
        if (b2b) begin
          b2b_checks++;
          check("b2b_gap", gap, 1);
        end
        b2b = 1'b0;
        bits.delete();
      end
      bits.push_back(Tx_out);
    end else begin
      if (collecting != 0) begin
        collecting = 0;
        frames++;
        last_len = bits.size();
        last_bits = bits;
        if (exq.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          it = exq.pop_front();
          e.delete();
          for (int k = 0; k < CPB; k++) e.push_back(1'b0);
          for (int b = 0; b < DW; b++)
            for (int k = 0; k < CPB; k++) e.push_back(it.d[b]);
          if (it.pen) begin
            ones = $countones(it.d);
            p = 1'((ones % 2) == 1) ^ it.ptyp;
            for (int k = 0; k < CPB; k++) e.push_back(p);
          end
          for (int k = 0; k < CPB; k++) e.push_back(1'b1);
          bad_idx = -1;
          if (e.size() == bits.size()) begin
            for (int k = 0; k < e.size(); k++)
              if (bad_idx < 0 && e[k] !== bits[k]) bad_idx = k;
          end
          n_cmp++;
          if (e.size() != bits.size() || bad_idx >= 0) begin
            n_bad++;
            $display("FAIL frame data=%02h pen=%0d ptyp=%0d: got len %0d expected len %0d, first bad cycle %0d",
                     it.d, it.pen, it.ptyp, bits.size(), e.size(), bad_idx);
          end
        end
        gap = 1;
        b2b = !Rempty;
      end else begin
        gap++;
      end
      if (Tx_out !== 1'b1) idle_low++;
    end
  end

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while ((fq.size() != 0 || exq.size() != 0 || Busy || collecting != 0) && n < budget) begin
      @(negedge Rclk);
      n++;
    end
    if (n >= budget) check({name, "_timeout"}, n, 0);
    repeat (3) @(negedge Rclk);
  endtask

  initial begin
    int bad;
    int r0;
    int f0;
    int c0;
    int n;

    // Reset held with data waiting in the FIFO.
    push_item(8'hA5, 1'b1, 1'b0);
    bad = 0;
    repeat (10) begin
      @(negedge Rclk);
      if (Tx_out !== 1'b1 || Rinc !== 1'b0 || Busy !== 1'b0) bad++;
    end
    check("reset_hold", bad, 0);
    Rrst = 1'b0;

    r0 = rinc_cnt;
    wait_done(300, "a5");
    check("a5_len", last_len, 44);
    check("a5_rinc", rinc_cnt - r0, 1);

    push_item(8'h0B, 1'b1, 1'b1);
    wait_done(300, "odd");
    check("odd_len", last_len, 44);
    check("odd_par_bit", int'(last_bits[36]), 0);

    push_item(8'h0B, 1'b0, 1'b1);
    wait_done(300, "nopar");
    check("nopar_len", last_len, 40);

    // Empty FIFO for 100 cycles.
    r0 = rinc_cnt;
    bad = 0;
    repeat (100) begin
      @(negedge Rclk);
      if (Tx_out !== 1'b1) bad++;
    end
    check("empty_rinc", rinc_cnt - r0, 0);
    check("empty_line_low", bad, 0);

    // Back-to-back burst of eight words.
    r0 = rinc_cnt;
    f0 = frames;
    c0 = b2b_checks;
    for (int i = 0; i < 8; i++) push_item(8'(8'h51 + i), 1'($urandom), 1'($urandom));
    wait_done(3000, "b2b");
    check("b2b_frames", frames - f0, 8);
    check("b2b_rinc", rinc_cnt - r0, 8);
    check("b2b_gaps", b2b_checks - c0, 7);
    check("b2b_rempty", int'(Rempty), 1);
    r0 = rinc_cnt;
    repeat (20) @(negedge Rclk);
    check("b2b_no_more_rinc", rinc_cnt - r0, 0);

    // Random bursts with random gaps; FWFT data changes under in-flight frames.
    r0 = rinc_cnt;
    f0 = frames;
    for (int b = 0; b < 12; b++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) push_item(8'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 150)) @(negedge Rclk);
    end
    wait_done(20000, "rand");
    check("rand_frames_vs_pops", frames - f0, rinc_cnt - r0);

    // Reset asserted mid-DATA.
    push_item(8'h3C, 1'b1, 1'b0);
    push_item(8'hC3, 1'b1, 1'b1);
    n = 0;
    while (!Busy && n < 100) begin
      @(negedge Rclk);
      n++;
    end
    if (n >= 100) check("mid_busy_timeout", n, 0);
    repeat (20) @(posedge Rclk);
    #3 Rrst = 1'b1;
    #1;
    check("mid_rst_tx_async", int'(Tx_out), 1);
    check("mid_rst_busy", int'(Busy), 0);
    r0 = rinc_cnt;
    repeat (5) @(negedge Rclk);
    check("mid_rst_no_rinc", rinc_cnt - r0, 0);
    Rrst = 1'b0;
    f0 = frames;
    r0 = rinc_cnt;
    wait_done(300, "mid_after");
    check("mid_after_frames", frames - f0, 1);
    check("mid_after_rinc", rinc_cnt - r0, 1);

    check("idle_line_low", idle_low, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer of the asynchronous FIFO, running entirely in the read-clock domain. It pops one byte at a time through the FIFO's `Rinc`/`Rempty`/`Rdata` port and serializes it as a UART frame: start bit, LSB-first data, optional parity, stop bit. It is the stage directly downstream of the async FIFO and drives the serial transmit line of the system.

## Interface
- `Data_width`, 8: width of one FIFO word and of the serialized payload.
- `Clks_per_bit`, 4: `Rclk` cycles per serial bit; must be ≥ 2.
- `Rclk` in 1: read-domain clock. One clock only.
- `Rrst` in 1: reset, asynchronous and active-high.
- `Rempty` in 1: FIFO empty flag.
- `Rdata` in `Data_width`: FIFO read data, first-word-fall-through (valid whenever `Rempty` = 0).
- `Par_en` in 1: 1 inserts a parity bit; sampled at pop.
- `Par_typ` in 1: 0 even, 1 odd; sampled at pop.
- `Rinc` out 1: FIFO pop strobe, one-cycle pulse.
- `Tx_out` out 1: serial line, idle high.
- `Busy` out 1: frame in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `Tx_out` = 1, `Busy` = 0.
  - If `Rempty` = 0, assert `Rinc` for exactly one cycle.
  - On that same edge, capture `Rdata`, `Par_en` and `Par_typ`, then go to START.
- START: `Tx_out` = 0 for `Clks_per_bit` cycles, then go to DATA.
- DATA:
  - Shift out captured bits LSB first, each for `Clks_per_bit` cycles.
  - A bit index counts 0..`Data_width`-1.
  - After the last bit, go to PARITY if captured `Par_en` = 1, else to STOP.
- PARITY: `Tx_out` = XOR-reduce of the data for even parity, its inverse for odd, held `Clks_per_bit` cycles.
- STOP: `Tx_out` = 1 for `Clks_per_bit` cycles, then go to IDLE.
- `Rinc` is never asserted while `Rempty` = 1 and never outside IDLE. Exactly one pop per frame.
- Changes to `Rdata`, `Par_en` or `Par_typ` after capture do not affect the frame in flight.
- Reset (any time, including mid-frame):
  - state IDLE, `Tx_out` = 1, `Rinc` = 0, `Busy` = 0, counters 0.
  - A partially sent byte is dropped and not re-popped.

## Timing
- All outputs are registered. `Rinc` is the only output that is combinational from state and `Rempty`; it is 0 in all non-IDLE states.
- Pop-to-start: `Tx_out` falls on the edge after the `Rinc` cycle.
- Frame length: (2 + `Data_width` + `Par_en`) × `Clks_per_bit` cycles.
- `Busy` rises with the first START cycle and falls after the last STOP cycle.
- Back-to-back: when the FIFO is non-empty at the end of STOP, there is exactly one IDLE cycle (line high, `Rinc` = 1) before the next START. The stop bit is therefore effectively `Clks_per_bit` + 1 cycles.
- `Rempty` update latency after a pop is ≤ 2 cycles. It is always shorter than a frame, so a stale `Rempty` can never cause a double pop.
- Bit counter width: clog2(`Clks_per_bit`). It wraps from `Clks_per_bit`-1 to 0 and produces a one-cycle bit-end tick.

## Structure
- Shared package `fifo_uart_tx_pkg`:
  - state encoding localparams (3-bit: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4).
  - parity-type constants `PAR_EVEN`/`PAR_ODD`.
- One sub-module, `bit_tick_counter`:
  - parameter `Clks_per_bit`.
  - inputs `Rclk`, `Rrst`, `En`.
  - output `Tick`, asserted on the last cycle of each bit.
- FSM, shift register and parity logic live in the top level.

## Test plan
- Reset: hold `Rrst` = 1 with `Rempty` = 0 → `Tx_out` = 1, `Rinc` = 0, `Busy` = 0 throughout. Assert `Rrst` mid-DATA → `Tx_out` = 1 asynchronously and no further `Rinc` until `Rrst` drops.
- Single byte, 0xA5, `Par_en` = 1, `Par_typ` = 0, `Clks_per_bit` = 4:
  - one `Rinc` pulse.
  - line sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles.
  - 44 cycles total, `Busy` high for 44 cycles.
- Odd parity, no-parity frame:
  - 0x0B with `Par_typ` = 1 → parity bit 0.
  - same byte with `Par_en` = 0 → 10-bit frame, 40 cycles, no parity slot.
- Empty FIFO: `Rempty` = 1 for 100 cycles → zero `Rinc` pulses, `Tx_out` constant 1.
- Back-to-back with the async FIFO instantiated:
  - write 0x51..0x58 from the `Wclk` side.
  - expect 8 frames in order, each separated by exactly one idle-high cycle.
  - expect 8 `Rinc` pulses; `Rempty` = 1 after the 8th pop; no `Rinc` afterwards.
- Mid-frame input change: alter `Rdata` and `Par_typ` during DATA → transmitted bits still match the captured values.
